vram_arbiter: RTL and testbench

- Shares one single-port synchronous video character RAM between the text-mode video fetch pipeline and the 6502 CPU bus.
- Video fetches have strict priority and a fixed, known latency, so the video sync/DE delay line can be matched to it.
- CPU accesses are latched, issued in the first free slot, and acknowledged with a one-cycle pulse.
- Sits between the video timing/character fetch logic and the VRAM instance, in the pixel clock domain.

---
 rtl/vram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for a single-port character RAM: video has strict priority, fixed 1+RAM_LAT latency.
// CPU request is latched and acked after 2+RAM_LAT cycles plus stalls. Optional stall counter: VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic [DW-1:0] vid_data_o,
  output logic          vid_valid_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_busy_o,
  output logic          cpu_ovr_o,
  input  logic          cpu_ovr_clr_i,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]   cpu_stall_cnt_o,
`endif
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int NT = RAM_LAT + 1;

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_WAIT} cstate_e;

  cstate_e       state_q, state_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          ram_ce_q, ram_ce_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [NT-1:0] tag_vld_q, tag_vld_d;
  logic [NT-1:0] tag_cpu_q, tag_cpu_d;
  logic [NT-1:0] tag_we_q, tag_we_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ovr_q, ovr_d;
  logic          slot_vld, slot_cpu, slot_we;
  logic          tail_ack, tail_vid, tail_rd;

  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    slot_vld    = 1'b0;
    slot_cpu    = 1'b0;
    slot_we     = 1'b0;
    ovr_d       = ovr_q;
    rdata_d     = rdata_q;
    tail_ack    = tag_vld_q[NT-1] & tag_cpu_q[NT-1];
    tail_vid    = tag_vld_q[NT-1] & ~tag_cpu_q[NT-1];
    tail_rd     = tail_ack & ~tag_we_q[NT-1];

    // Video always owns the slot; a pending CPU access only uses otherwise idle cycles.
    if (vid_req_i) begin
      ram_ce_d   = 1'b1;
      ram_addr_d = vid_addr_i;
      slot_vld   = 1'b1;
    end else if (state_q == C_PEND) begin
      ram_ce_d    = 1'b1;
      ram_we_d    = lat_we_q;
      ram_addr_d  = lat_addr_q;
      ram_wdata_d = lat_we_q ? lat_wdata_q : '0;
      slot_vld    = 1'b1;
      slot_cpu    = 1'b1;
      slot_we     = lat_we_q;
    end

    tag_vld_d = {tag_vld_q[NT-2:0], slot_vld};
    tag_cpu_d = {tag_cpu_q[NT-2:0], slot_cpu};
    tag_we_d  = {tag_we_q[NT-2:0], slot_we};

    case (state_q)
      C_IDLE: begin
        if (cpu_req_i) begin
          lat_we_d    = cpu_we_i;
          lat_addr_d  = cpu_addr_i;
          lat_wdata_d = cpu_wdata_i;
          state_d     = C_PEND;
        end
      end
      C_PEND:  if (!vid_req_i) state_d = C_WAIT;
      C_WAIT:  if (tail_ack) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase

    // Set beats clear when both land in the same cycle.
    if (cpu_ovr_clr_i) ovr_d = 1'b0;
    if (cpu_req_i && (state_q != C_IDLE)) ovr_d = 1'b1;

    if (tail_rd) rdata_d = ram_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= C_IDLE;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_vld_q   <= '0;
      tag_cpu_q   <= '0;
      tag_we_q    <= '0;
      rdata_q     <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_cpu_q   <= tag_cpu_d;
      tag_we_q    <= tag_we_d;
      rdata_q     <= rdata_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_ovr_clr_i)
      stall_cnt_d = '0;
    else if ((state_q == C_PEND) && vid_req_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign cpu_stall_cnt_o = stall_cnt_q;
`endif

  assign vid_valid_o = tail_vid;
  assign vid_data_o  = tail_vid ? ram_rdata_i : '0;
  assign cpu_ack_o   = tail_ack;
  assign cpu_rdata_o = tail_rd ? ram_rdata_i : rdata_q;
  assign cpu_busy_o  = (state_q != C_IDLE);
  assign cpu_ovr_o   = ovr_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: three instances (RAM_LAT 1..3) share stimulus; each has its own RAM model
// and an event-queue reference model. Directed table on the RAM_LAT=1 instance, then reset and random phases.
module tb_vram_arbiter;
  localparam int NI = 3;

  logic        clk, rst, init_go;
  logic        vid_req, cpu_req, cpu_we, ovr_clr;
  logic [10:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        d_vid_valid [NI];
  logic [7:0]  d_vid_data  [NI];
  logic        d_ack       [NI];
  logic [7:0]  d_cpu_rdata [NI];
  logic        d_busy      [NI];
  logic        d_ovr       [NI];
  logic        d_ce        [NI];
  logic        d_we        [NI];
  logic [10:0] d_addr      [NI];
  logic [7:0]  d_wdata     [NI];
  logic [7:0]  d_rdata     [NI];
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] d_stall     [NI];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] mem [2048];
    logic [7:0] pipe [3];

    vram_arbiter #(.AW(11), .DW(8), .RAM_LAT(g + 1)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .vid_req_i      (vid_req),
      .vid_addr_i     (vid_addr),
      .vid_data_o     (d_vid_data[g]),
      .vid_valid_o    (d_vid_valid[g]),
      .cpu_req_i      (cpu_req),
      .cpu_we_i       (cpu_we),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_rdata_o    (d_cpu_rdata[g]),
      .cpu_ack_o      (d_ack[g]),
      .cpu_busy_o     (d_busy[g]),
      .cpu_ovr_o      (d_ovr[g]),
      .cpu_ovr_clr_i  (ovr_clr),
`ifdef VRAM_ARB_STATS_EN
      .cpu_stall_cnt_o(d_stall[g]),
`endif
      .ram_ce_o       (d_ce[g]),
      .ram_we_o       (d_we[g]),
      .ram_addr_o     (d_addr[g]),
      .ram_wdata_o    (d_wdata[g]),
      .ram_rdata_i    (d_rdata[g])
    );

    // Synchronous RAM: samples the bus at an edge, read data appears g+1 edges later.
    always @(posedge clk) begin
      if (init_go) begin
        for (int a = 0; a < 2048; a++) mem[a] <= 8'(a * 7 + 3);
      end else if (d_ce[g] && d_we[g]) begin
        mem[d_addr[g]] <= d_wdata[g];
      end
      pipe[0] <= (d_ce[g] && !d_we[g]) ? mem[d_addr[g]] : 8'hEE;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign d_rdata[g] = pipe[g];
  end

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  bit chk_on = 0;

  // Reference model: expected events keyed by the cycle they must appear in (ring of 8).
  bit          r_vv  [NI][8];
  logic [7:0]  r_vd  [NI][8];
  bit          r_ack [NI][8];
  bit          r_rd  [NI][8];
  logic [7:0]  r_ad  [NI][8];
  logic [7:0]  refmem [NI][2048];
  bit          m_pend [NI];
  int          m_ack_at [NI];
  bit          m_we [NI];
  logic [10:0] m_addr [NI];
  logic [7:0]  m_wdata [NI];
  bit          m_ovr [NI];
  logic [7:0]  m_rdata [NI];
  int          m_stall [NI];
  bit          x_ce [NI];
  bit          x_we [NI];
  logic [10:0] x_addr [NI];
  logic [7:0]  x_wdata [NI];

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    for (int s = 0; s < 8; s++) begin
      r_vv[i][s] = 0; r_ack[i][s] = 0; r_rd[i][s] = 0; r_vd[i][s] = '0; r_ad[i][s] = '0;
    end
    m_pend[i] = 0; m_ack_at[i] = -1; m_ovr[i] = 0; m_rdata[i] = '0; m_stall[i] = 0;
    x_ce[i] = 0; x_we[i] = 0; x_addr[i] = '0; x_wdata[i] = '0;
  endtask

  task automatic model_check();
    for (int i = 0; i < NI; i++) begin
      int s = cyc % 8;
      chk("vid_valid", i, 32'(d_vid_valid[i]), 32'(r_vv[i][s]));
      if (r_vv[i][s]) chk("vid_data", i, 32'(d_vid_data[i]), 32'(r_vd[i][s]));
      chk("cpu_ack", i, 32'(d_ack[i]), 32'(r_ack[i][s]));
      if (r_ack[i][s] && r_rd[i][s]) m_rdata[i] = r_ad[i][s];
      chk("cpu_rdata", i, 32'(d_cpu_rdata[i]), 32'(m_rdata[i]));
      chk("cpu_busy", i, 32'(d_busy[i]), 32'(m_pend[i] || (m_ack_at[i] >= cyc)));
      chk("cpu_ovr", i, 32'(d_ovr[i]), 32'(m_ovr[i]));
      chk("ram_ce", i, 32'(d_ce[i]), 32'(x_ce[i]));
      if (x_ce[i]) begin
        chk("ram_we", i, 32'(d_we[i]), 32'(x_we[i]));
        chk("ram_addr", i, 32'(d_addr[i]), 32'(x_addr[i]));
        if (x_we[i]) chk("ram_wdata", i, 32'(d_wdata[i]), 32'(x_wdata[i]));
      end
`ifdef VRAM_ARB_STATS_EN
      chk("stall_cnt", i, 32'(d_stall[i]), 32'(m_stall[i]));
`endif
      r_vv[i][s] = 0; r_ack[i][s] = 0; r_rd[i][s] = 0;
    end
  endtask

  // Apply the rules to this cycle's inputs; results land in future ring slots / next-cycle RAM bus.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int lat = i + 1;
      int s   = (cyc + 1 + lat) % 8;
      bit busy;
      if (rst) begin
        model_reset(i);
        continue;
      end
      busy = m_pend[i] || (m_ack_at[i] >= cyc);
      if (ovr_clr) m_stall[i] = 0;
      else if (m_pend[i] && vid_req && m_stall[i] < 65535) m_stall[i]++;
      x_ce[i] = 0; x_we[i] = 0; x_addr[i] = '0; x_wdata[i] = '0;
      if (vid_req) begin
        r_vv[i][s] = 1;
        r_vd[i][s] = refmem[i][vid_addr];
        x_ce[i] = 1; x_addr[i] = vid_addr;
      end else if (m_pend[i]) begin
        m_pend[i] = 0;
        m_ack_at[i] = cyc + 1 + lat;
        r_ack[i][s] = 1;
        r_rd[i][s] = !m_we[i];
        if (m_we[i]) refmem[i][m_addr[i]] = m_wdata[i];
        else r_ad[i][s] = refmem[i][m_addr[i]];
        x_ce[i] = 1; x_we[i] = m_we[i]; x_addr[i] = m_addr[i]; x_wdata[i] = m_wdata[i];
      end
      if (ovr_clr) m_ovr[i] = 0;
      if (cpu_req) begin
        if (busy) m_ovr[i] = 1;
        else begin
          m_pend[i] = 1; m_we[i] = cpu_we; m_addr[i] = cpu_addr; m_wdata[i] = cpu_wdata;
        end
      end
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    cyc++;
    if (chk_on) model_check();
  endtask

  task automatic set_idle();
    rst = 0; vid_req = 0; cpu_req = 0; ovr_clr = 0; cpu_we = 0;
  endtask

  typedef struct {
    bit vr; logic [10:0] va; bit cr; bit cw; logic [10:0] ca; logic [7:0] cd; bit clr;
    bit evv; logic [7:0] evd; bit eack; logic [7:0] erd; bit ebusy; bit eovr;
    bit ece; bit ewe; logic [10:0] eaddr;
  } vec_t;

  vec_t tbl [32];

  initial begin
    // Expected outputs are those of instance RAM_LAT=1 in the same cycle the row's inputs are applied.
    //            vr va      cr cw ca      cd    clr  evv evd   ack erd   bsy ovr  ce we addr
    tbl[0]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 11'h000};
    tbl[1]  = '{1, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 11'h000};
    tbl[2]  = '{1, 11'h7FF, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0,  1, 0, 11'h000};
    tbl[3]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  1, 8'h03, 0, 8'h00, 0, 0,  1, 0, 11'h7FF};
    tbl[4]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  1, 8'hFC, 0, 8'h00, 0, 0,  0, 0, 11'h000};
    tbl[5]  = '{0, 11'h000, 1, 1, 11'h123, 8'h5A, 0,  0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 11'h000};
    tbl[6]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 11'h000};
    tbl[7]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 1, 0,  1, 1, 11'h123};
    tbl[8]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 1, 8'h00, 1, 0,  0, 0, 11'h000};
    tbl[9]  = '{0, 11'h000, 1, 0, 11'h123, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 11'h000};
    tbl[10] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 11'h000};
    tbl[11] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h00, 1, 0,  1, 0, 11'h123};
    tbl[12] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 1, 8'h5A, 1, 0,  0, 0, 11'h000};
    tbl[13] = '{1, 11'h020, 1, 1, 11'h010, 8'h33, 0,  0, 8'h00, 0, 8'h5A, 0, 0,  0, 0, 11'h000};
    tbl[14] = '{1, 11'h021, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h5A, 1, 0,  1, 0, 11'h020};
    tbl[15] = '{1, 11'h022, 0, 0, 11'h000, 8'h00, 0,  1, 8'hE3, 0, 8'h5A, 1, 0,  1, 0, 11'h021};
    tbl[16] = '{1, 11'h023, 0, 0, 11'h000, 8'h00, 0,  1, 8'hEA, 0, 8'h5A, 1, 0,  1, 0, 11'h022};
    tbl[17] = '{1, 11'h024, 0, 0, 11'h000, 8'h00, 0,  1, 8'hF1, 0, 8'h5A, 1, 0,  1, 0, 11'h023};
    tbl[18] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  1, 8'hF8, 0, 8'h5A, 1, 0,  1, 0, 11'h024};
    tbl[19] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  1, 8'hFF, 0, 8'h5A, 1, 0,  1, 1, 11'h010};
    tbl[20] = '{0, 11'h000, 1, 0, 11'h010, 8'h00, 0,  0, 8'h00, 1, 8'h5A, 1, 0,  0, 0, 11'h000};
    tbl[21] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h5A, 0, 1,  0, 0, 11'h000};
    tbl[22] = '{0, 11'h000, 1, 0, 11'h010, 8'h00, 0,  0, 8'h00, 0, 8'h5A, 0, 1,  0, 0, 11'h000};
    tbl[23] = '{0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0,  0, 8'h00, 0, 8'h5A, 1, 1,  0, 0, 11'h000};
    tbl[24] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 1,  0, 8'h00, 0, 8'h5A, 1, 1,  1, 0, 11'h010};
    tbl[25] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 1, 8'h33, 1, 0,  0, 0, 11'h000};
    tbl[26] = '{0, 11'h000, 1, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h33, 0, 0,  0, 0, 11'h000};
    tbl[27] = '{0, 11'h000, 1, 0, 11'h7FF, 8'h00, 1,  0, 8'h00, 0, 8'h33, 1, 0,  0, 0, 11'h000};
    tbl[28] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h33, 1, 1,  1, 0, 11'h000};
    tbl[29] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 1, 8'h03, 1, 1,  0, 0, 11'h000};
    tbl[30] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 1,  0, 8'h00, 0, 8'h03, 0, 1,  0, 0, 11'h000};
    tbl[31] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0,  0, 8'h00, 0, 8'h03, 0, 0,  0, 0, 11'h000};

    set_idle();
    rst = 1; init_go = 1;
    vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 2048; a++) refmem[i][a] = 8'(a * 7 + 3);
      model_reset(i);
    end
    cyc_begin();
    init_go = 0;
    model_update();
    chk_on = 1;

    for (int k = 0; k < 32; k++) begin
      cyc_begin();
      chk($sformatf("t%0d_vvalid", k), 0, 32'(d_vid_valid[0]), 32'(tbl[k].evv));
      if (tbl[k].evv) chk($sformatf("t%0d_vdata", k), 0, 32'(d_vid_data[0]), 32'(tbl[k].evd));
      chk($sformatf("t%0d_ack", k), 0, 32'(d_ack[0]), 32'(tbl[k].eack));
      chk($sformatf("t%0d_rdata", k), 0, 32'(d_cpu_rdata[0]), 32'(tbl[k].erd));
      chk($sformatf("t%0d_busy", k), 0, 32'(d_busy[0]), 32'(tbl[k].ebusy));
      chk($sformatf("t%0d_ovr", k), 0, 32'(d_ovr[0]), 32'(tbl[k].eovr));
      chk($sformatf("t%0d_ce", k), 0, 32'(d_ce[0]), 32'(tbl[k].ece));
      if (tbl[k].ece) begin
        chk($sformatf("t%0d_we", k), 0, 32'(d_we[0]), 32'(tbl[k].ewe));
        chk($sformatf("t%0d_addr", k), 0, 32'(d_addr[0]), 32'(tbl[k].eaddr));
      end
      set_idle();
      vid_req = tbl[k].vr; vid_addr = tbl[k].va;
      cpu_req = tbl[k].cr; cpu_we = tbl[k].cw; cpu_addr = tbl[k].ca; cpu_wdata = tbl[k].cd;
      ovr_clr = tbl[k].clr;
      model_update();
    end

    // Reset while the RAM_LAT=3 instance has a CPU write and video reads in flight.
    repeat (6) begin cyc_begin(); set_idle(); model_update(); end
    cyc_begin(); set_idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h055; cpu_wdata = 8'h77; vid_req = 1; vid_addr = 11'h100;
    model_update();
    cyc_begin(); set_idle(); model_update();
    cyc_begin(); set_idle(); vid_req = 1; vid_addr = 11'h102; model_update();
    cyc_begin(); chk("rst_pre_busy", 2, 32'(d_busy[2]), 32'd1);
    set_idle(); rst = 1; model_update();
    cyc_begin();
    for (int i = 0; i < NI; i++) begin
      chk("rst_zero_a", i, 32'({d_vid_valid[i], d_vid_data[i], d_ack[i], d_cpu_rdata[i], d_busy[i], d_ovr[i]}), 32'd0);
      chk("rst_zero_b", i, 32'({d_ce[i], d_we[i], d_addr[i], d_wdata[i]}), 32'd0);
    end
    set_idle(); model_update();
    repeat (8) begin cyc_begin(); set_idle(); model_update(); end

    for (int n = 0; n < 3000; n++) begin
      cyc_begin();
      set_idle();
      rst       = ($urandom_range(0, 299) == 0);
      vid_req   = ($urandom_range(0, 3) == 0);
      vid_addr  = $urandom_range(0, 1) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047));
      cpu_req   = ($urandom_range(0, 4) == 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 11'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      ovr_clr   = ($urandom_range(0, 19) == 0);
      model_update();
    end
    repeat (10) begin cyc_begin(); set_idle(); model_update(); end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
